// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: start, DATA_WIDTH data bits (LSB first), optional parity, stop bit(s).
// Define UART_TX_STOP2_EN to append a second stop bit to every frame.
module uart_tx_frame_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned     CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
`ifdef UART_TX_STOP2_EN
        StStop   = 3'd4,
        StStop2  = 3'd5
`else
        StStop   = 3'd4
`endif
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  pen_q;
    logic                  par_q;
    logic [CntW-1:0]       cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            data_q  <= '0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            TX_OUT  <= 1'b1;
            Busy    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (Data_Valid) begin
                        state_q <= StStart;
                        data_q  <= P_DATA;
                        pen_q   <= PAR_EN;
                        TX_OUT  <= 1'b0;
                        Busy    <= 1'b1;
                    end else begin
                        TX_OUT  <= 1'b1;
                        Busy    <= 1'b0;
                    end
                end
                StStart: begin
                    // Parity calculator output is settled by the end of the start bit.
                    par_q   <= par_bit;
                    cnt_q   <= '0;
                    state_q <= StData;
                    TX_OUT  <= data_q[0];
                    data_q  <= data_q >> 1;
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        state_q <= pen_q ? StParity : StStop;
                        TX_OUT  <= pen_q ? par_q : 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        TX_OUT  <= data_q[0];
                        data_q  <= data_q >> 1;
                    end
                end
                StParity: begin
                    state_q <= StStop;
                    TX_OUT  <= 1'b1;
                end
`ifdef UART_TX_STOP2_EN
                StStop: begin
                    state_q <= StStop2;
                    TX_OUT  <= 1'b1;
                end
                StStop2: begin
`else
                StStop: begin
`endif
                    // Last stop bit: a new request chains straight into the next start bit.
                    if (Data_Valid) begin
                        state_q <= StStart;
                        data_q  <= P_DATA;
                        pen_q   <= PAR_EN;
                        TX_OUT  <= 1'b0;
                        Busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        TX_OUT  <= 1'b1;
                        Busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    TX_OUT  <= 1'b1;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: directed and random requests checked against a line-bit queue model.
module tb_uart_tx_frame_ctrl;

    localparam int W = 8;
`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         par_bit;
    logic         TX_OUT;
    logic         Busy;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    // Expected line bits still to appear, head = bit on the line this cycle.
    logic exp_q[$];
    bit   pend = 1'b0;
    int   pidx = 0;

    uart_tx_frame_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .par_bit    (par_bit),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [W-1:0] rw();
        return W'($urandom);
    endfunction

    // A frame is accepted whenever no bits of the previous frame remain after this edge.
    function automatic void model_edge(input logic dv, input logic [W-1:0] pd, input logic pen,
                                       input logic pb);
        if (pend) begin
            exp_q[pidx] = pb;
            pend = 1'b0;
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (dv && exp_q.size() == 0) begin
            exp_q.push_back(1'b0);
            for (int i = 0; i < W; i++) exp_q.push_back(pd[i]);
            if (pen) begin
                pend = 1'b1;
                pidx = 1 + W;
                exp_q.push_back(1'b0);
            end
            for (int i = 0; i < NSTOP; i++) exp_q.push_back(1'b1);
        end
    endfunction

    task automatic check_out(input string tag);
        logic etx;
        logic ebusy;
        etx   = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
        ebusy = (exp_q.size() > 0);
        total++;
        assert (TX_OUT === etx) else begin
            bad++;
            $error("FAIL %s tx cyc=%0d got=%b exp=%b", tag, ncyc, TX_OUT, etx);
        end
        total++;
        assert (Busy === ebusy) else begin
            bad++;
            $error("FAIL %s busy cyc=%0d got=%b exp=%b", tag, ncyc, Busy, ebusy);
        end
    endtask

    // Drive one cycle's inputs (called just after a falling edge), then check mid-cycle.
    task automatic cyc(input logic dv, input logic [W-1:0] pd, input logic pen, input logic pb,
                       input string tag);
        Data_Valid = dv;
        P_DATA     = pd;
        PAR_EN     = pen;
        par_bit    = pb;
        @(posedge CLK);
        model_edge(dv, pd, pen, pb);
        ncyc++;
        @(negedge CLK);
        check_out(tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) cyc(1'b0, rw(), rb(), rb(), tag);
    endtask

    initial begin
        RST        = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        par_bit    = 1'b0;
        @(negedge CLK);
        check_out("reset");
        RST = 1'b1;
        idle(2, "post_reset");

        // 8'hA5 without parity
        cyc(1'b1, 8'hA5, 1'b0, rb(), "a5");
        idle(12, "a5");

        // 8'h03 with parity 0, then parity 1
        cyc(1'b1, 8'h03, 1'b1, rb(), "p0");
        cyc(1'b0, rw(), rb(), 1'b0, "p0");
        idle(12, "p0");
        cyc(1'b1, 8'h03, 1'b1, rb(), "p1");
        cyc(1'b0, rw(), rb(), 1'b1, "p1");
        idle(12, "p1");

        // 8'h00 frame with 8'hFF requests and par_bit toggling during data
        cyc(1'b1, 8'h00, 1'b1, rb(), "noise");
        cyc(1'b0, rw(), rb(), 1'b0, "noise");
        for (int i = 0; i < W; i++) cyc((i >= 2 && i <= 5), 8'hFF, 1'b1, 1'(i), "noise");
        idle(6, "noise");

        // Back-to-back: request on the last stop cycle
        cyc(1'b1, 8'hA5, 1'b0, rb(), "chain");
        for (int i = 0; i < 40 && exp_q.size() != 1; i++) idle(1, "chain");
        cyc(1'b1, 8'h55, 1'b0, rb(), "chain");
        idle(14, "chain");

        // Asynchronous reset during data bit 4 of 8'hF0
        cyc(1'b1, 8'hF0, 1'b0, rb(), "rst_mid");
        idle(5, "rst_mid");
        RST = 1'b0;
        #1;
        exp_q.delete();
        pend = 1'b0;
        check_out("rst_async");
        Data_Valid = 1'b1;
        @(negedge CLK);
        check_out("rst_hold");
        RST = 1'b1;
        idle(4, "rst_release");

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 3) == 0), rw(), rb(), rb(), "rand");
        idle(14, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
